// File: rtl/bldc_motor_driver.sv
// Six-step BLDC commutation controller: Hall sync/filter, direction, dead time, invalid-Hall fault.
// Optional stall timer compiled in with `define BLDC_STALL_DETECT_EN.
module bldc_motor_driver #(
  parameter int FILT_CYCLES  = 4,
  parameter int DEAD_CYCLES  = 8,
  parameter int STALL_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       dir,
  input  logic [2:0] H,
  output logic [1:0] A,
  output logic [1:0] B,
  output logic [1:0] C,
  output logic       fault,
  output logic       stall
);

  localparam int FW = $clog2(FILT_CYCLES + 1);
  localparam int DW = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;

  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_cand;
  logic [FW-1:0] r_filtCnt;
  logic [2:0]    r_hallQ;
  logic          r_fault;
  logic [5:0]    r_gates;
  logic [DW-1:0] r_deadCnt;

  logic          w_hallLoad;
  logic          w_hallChange;
  logic          w_stall;
  logic [5:0]    w_table;
  logic [5:0]    w_target;

  // A new sample restarts the run; the code is accepted on the FILT_CYCLES-th identical sample.
  assign w_hallLoad   = (r_sync2 != r_cand) ? (FILT_CYCLES == 1)
                                            : (r_filtCnt == FW'(FILT_CYCLES - 1));
  assign w_hallChange = w_hallLoad && (r_sync2 != r_hallQ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 3'b000;
      r_sync2   <= 3'b000;
      r_cand    <= 3'b000;
      r_filtCnt <= '0;
      r_hallQ   <= 3'b000;
      r_fault   <= 1'b0;
    end else begin
      r_sync1 <= H;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_cand) begin
        r_cand    <= r_sync2;
        r_filtCnt <= FW'(1);
      end else if (r_filtCnt < FW'(FILT_CYCLES)) begin
        r_filtCnt <= r_filtCnt + FW'(1);
      end
      if (w_hallLoad) begin
        r_hallQ <= r_sync2;
      end
      r_fault <= (r_hallQ == 3'b000) || (r_hallQ == 3'b111);
    end
  end

`ifdef BLDC_STALL_DETECT_EN
  localparam int SW = $clog2(STALL_CYCLES + 1);

  logic [SW-1:0] r_stallCnt;
  logic          r_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stallCnt <= '0;
      r_stall    <= 1'b0;
    end else if (!en) begin
      r_stallCnt <= '0;
      r_stall    <= 1'b0;
    end else if (w_hallChange) begin
      r_stallCnt <= '0;
    end else if (r_stallCnt == SW'(STALL_CYCLES)) begin
      r_stall <= 1'b1;
    end else begin
      r_stallCnt <= r_stallCnt + SW'(1);
    end
  end

  assign w_stall = r_stall;
`else
  logic w_unusedChange;
  assign w_unusedChange = w_hallChange;
  assign w_stall        = 1'b0;
`endif

  always_comb begin
    w_table = 6'b000000;
    case (r_hallQ)
      3'b101:  w_table = 6'b10_01_00;
      3'b100:  w_table = 6'b10_00_01;
      3'b110:  w_table = 6'b00_10_01;
      3'b010:  w_table = 6'b01_10_00;
      3'b011:  w_table = 6'b01_00_10;
      3'b001:  w_table = 6'b00_01_10;
      default: w_table = 6'b000000;
    endcase
    // Reverse rotation exchanges high and low side of every phase.
    w_target = dir ? {w_table[4], w_table[5], w_table[2], w_table[3], w_table[0], w_table[1]}
                   : w_table;
    if (!en || w_stall) begin
      w_target = 6'b000000;
    end
  end

  // Dead time counts down with the bridge off; the target is loaded on the edge the count leaves 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gates   <= 6'b000000;
      r_deadCnt <= '0;
    end else if (w_target == 6'b000000) begin
      r_gates   <= 6'b000000;
      r_deadCnt <= '0;
    end else if (w_target == r_gates) begin
      r_gates <= r_gates;
    end else if (r_deadCnt != '0) begin
      r_deadCnt <= r_deadCnt - DW'(1);
      if (r_deadCnt == DW'(1)) begin
        r_gates <= w_target;
      end
    end else if ((r_gates == 6'b000000) || (DEAD_CYCLES == 0)) begin
      r_gates <= w_target;
    end else begin
      r_gates   <= 6'b000000;
      r_deadCnt <= DW'(DEAD_CYCLES);
    end
  end

  assign A     = r_gates[5:4];
  assign B     = r_gates[3:2];
  assign C     = r_gates[1:0];
  assign fault = r_fault;
  assign stall = w_stall;

endmodule

// File: tb/tb_bldc_motor_driver.sv
// Directed self-checking bench for bldc_motor_driver (default FILT=4, DEAD=8).
// Stall steps are included when BLDC_STALL_DETECT_EN is defined.
module tb_bldc_motor_driver;

  logic       clk;
  logic       rst;
  logic       en;
  logic       dir;
  logic [2:0] H;
  logic [1:0] A;
  logic [1:0] B;
  logic [1:0] C;
  logic       fault;
  logic       stall;

  int checks = 0;
  int errors = 0;

  logic [5:0] prevGates;

  bldc_motor_driver #(
    .FILT_CYCLES (4),
    .DEAD_CYCLES (8),
    .STALL_CYCLES(100)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .dir  (dir),
    .H    (H),
    .A    (A),
    .B    (B),
    .C    (C),
    .fault(fault),
    .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic enV, input logic dirV, input logic [2:0] hV);
    en  = enV;
    dir = dirV;
    H   = hV;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Bridge safety watch: no shoot-through, no active-to-active switch without an off gap.
  always @(negedge clk) begin
    if (rst) begin
      prevGates = 6'b000000;
    end else begin
      checks++;
      assert ((A != 2'b11) && (B != 2'b11) && (C != 2'b11))
      else begin
        errors++;
        $error("[TB] FAIL shootThrough observed=%b expected=no 11 phase", {A, B, C});
      end
      checks++;
      assert (!((prevGates != 6'b0) && ({A, B, C} != 6'b0) && ({A, B, C} != prevGates)))
      else begin
        errors++;
        $error("[TB] FAIL deadGap observed=%b after %b expected=off between", {A, B, C}, prevGates);
      end
      prevGates = {A, B, C};
    end
  end

  logic [2:0] hSeq [6];
  logic [5:0] fwdSeq [6];

  initial begin
    hSeq   = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    fwdSeq = '{6'b100100, 6'b100001, 6'b001001, 6'b011000, 6'b010010, 6'b000110};

    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 3'b101);
    tick(2);
    checkOutput("resetGates", {2'b0, A, B, C}, 8'h00);
    checkOutput("resetFault", {7'b0, fault}, 8'h00);
    checkOutput("resetStall", {7'b0, stall}, 8'h00);

    $display("[TB] first drive after reset release");
    rst = 1'b0;
    tick(1);
    checkOutput("faultFromResetCode", {7'b0, fault}, 8'h01);
    tick(5);
    checkOutput("firstDriveEdge6", {2'b0, A, B, C}, 8'h00);
    tick(1);
    checkOutput("firstDriveEdge7", {2'b0, A, B, C}, {2'b0, 6'b100100});
    checkOutput("faultClearedEdge7", {7'b0, fault}, 8'h00);

    $display("[TB] commutation 101 -> 100");
    tick(10);
    applyStimulus(1'b1, 1'b0, 3'b100);
    tick(6);
    checkOutput("commHoldEdge6", {2'b0, A, B, C}, {2'b0, 6'b100100});
    tick(1);
    checkOutput("commOffEdge7", {2'b0, A, B, C}, 8'h00);
    tick(7);
    checkOutput("commOffEdge14", {2'b0, A, B, C}, 8'h00);
    tick(1);
    checkOutput("commNewEdge15", {2'b0, A, B, C}, {2'b0, 6'b100001});

    $display("[TB] full forward cycle");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, hSeq[i]);
      tick(50);
      checkOutput($sformatf("forwardStep%0d", i), {2'b0, A, B, C}, {2'b0, fwdSeq[i]});
    end

    applyStimulus(1'b1, 1'b1, 3'b101);
    tick(50);
    checkOutput("reverse101", {2'b0, A, B, C}, {2'b0, 6'b011000});

    $display("[TB] glitch rejection");
    applyStimulus(1'b1, 1'b0, 3'b101);
    tick(20);
    checkOutput("forwardAgain101", {2'b0, A, B, C}, {2'b0, 6'b100100});
    applyStimulus(1'b1, 1'b0, 3'b111);
    tick(3);
    applyStimulus(1'b1, 1'b0, 3'b101);
    for (int i = 0; i < 15; i++) begin
      tick(1);
      checkOutput($sformatf("glitchHold%0d", i), {2'b0, A, B, C}, {2'b0, 6'b100100});
    end
    checkOutput("glitchNoFault", {7'b0, fault}, 8'h00);

    $display("[TB] invalid Hall code");
    applyStimulus(1'b1, 1'b0, 3'b111);
    tick(6);
    checkOutput("invalidHoldEdge6", {2'b0, A, B, C}, {2'b0, 6'b100100});
    checkOutput("invalidFaultEdge6", {7'b0, fault}, 8'h00);
    tick(1);
    checkOutput("invalidOffEdge7", {2'b0, A, B, C}, 8'h00);
    checkOutput("invalidFaultEdge7", {7'b0, fault}, 8'h01);

    applyStimulus(1'b1, 1'b0, 3'b101);
    tick(50);
    checkOutput("recover101", {2'b0, A, B, C}, {2'b0, 6'b100100});
    checkOutput("recoverFault", {7'b0, fault}, 8'h00);
    applyStimulus(1'b0, 1'b0, 3'b101);
    tick(1);
    checkOutput("enableOff", {2'b0, A, B, C}, 8'h00);

`ifdef BLDC_STALL_DETECT_EN
    $display("[TB] stall detection");
    applyStimulus(1'b1, 1'b0, 3'b101);
    tick(120);
    checkOutput("stallSet", {7'b0, stall}, 8'h01);
    checkOutput("stallGatesOff", {2'b0, A, B, C}, 8'h00);
    applyStimulus(1'b0, 1'b0, 3'b101);
    tick(1);
    checkOutput("stallCleared", {7'b0, stall}, 8'h00);
`else
    checkOutput("stallTiedLow", {7'b0, stall}, 8'h00);
`endif

    $display("[TB] asynchronous reset mid-drive");
    applyStimulus(1'b1, 1'b0, 3'b101);
    tick(20);
    checkOutput("preResetDrive", {2'b0, A, B, C}, {2'b0, 6'b100100});
    rst = 1'b1;
    #2;
    checkOutput("asyncResetGates", {2'b0, A, B, C}, 8'h00);
    checkOutput("asyncResetFault", {7'b0, fault}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bldc_motor_driver.md
Name: bldc_motor_driver

Overview:
- Six-step (trapezoidal) commutation controller for a 3-phase BLDC bridge.
- Takes three raw Hall-effect sensor bits and drives the high-side/low-side gate enables of phases A, B and C.
- Sits between the Hall sensor pins and the gate-driver pins.
- Provides:
  - input synchronisation and glitch filtering;
  - direction control;
  - break-before-make dead time;
  - invalid-Hall fault detection.

Parameters:
- FILT_CYCLES, 4: consecutive identical synchronised Hall samples required before a new Hall code is accepted. Minimum 1.
- DEAD_CYCLES, 8: clocks the whole bridge is held off between two different active patterns. 0 is legal and means a direct switch.
- STALL_CYCLES, 1000000: stall timeout in clocks. Used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  drive enable; 0 forces all gates off
- dir  in  1  0 = forward, 1 = reverse
- H  in  3  raw Hall inputs {Hc,Hb,Ha}, asynchronous to clk
- A  out  2  phase A gates: [1] = high-side on, [0] = low-side on
- B  out  2  phase B gates, same encoding
- C  out  2  phase C gates, same encoding
- fault  out  1  accepted Hall code is invalid (000 or 111)
- stall  out  1  stall flag; constant 0 unless the optional feature is compiled in

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high; all registers clear immediately on its assertion.
- Reset values:
  - A = B = C = 00; fault = 0; stall = 0.
  - Synchroniser registers, accepted Hall code hall_q and all counters = 0.
- Synchroniser: H passes through two flops, giving sync2.
- Filter:
  - A counter tracks how many consecutive clocks sync2 has held the same value.
  - hall_q loads sync2 once that value has been held for FILT_CYCLES consecutive clocks.
  - Any change restarts the count. Shorter glitches are ignored.
  - Latency from a stable H to hall_q = 2 + FILT_CYCLES clocks.
- Forward commutation table, hall_q -> {A,B,C}:
  - 101 -> 10,01,00
  - 100 -> 10,00,01
  - 110 -> 00,10,01
  - 010 -> 01,10,00
  - 011 -> 01,00,10
  - 001 -> 00,01,10
- Reverse (dir = 1): the same table with bits [1] and [0] of every phase swapped (high and low exchanged).
- Target pattern = all 00 when en = 0, when hall_q is 000/111, or when stall = 1. Otherwise it is the table entry.
- fault is a registered copy of (hall_q == 000 or hall_q == 111); it updates one clock after hall_q.
- Output register rules, evaluated every clock:
  - target equals current outputs: hold.
  - target all-off: outputs go off on the next clock and any dead-time count aborts.
  - current outputs all-off and no dead-time count running: load target on the next clock.
  - current outputs active and target is a different active pattern: go all-off on the next clock and load the dead counter with DEAD_CYCLES.
  - dead counter nonzero: outputs stay off and the counter decrements. When it reaches 0, the latest target loads on the next clock.
  - A target change during dead time does not restart the count; the latest target wins.
- Invariant: no phase ever has both gate bits = 1. No active pattern is ever directly followed by a different active pattern when DEAD_CYCLES > 0.
- A phase that stays driven across a commutation is still switched off for the dead time, because the whole bridge goes off.

Optional Feature:
- Macro: BLDC_STALL_DETECT_EN.
- Defined:
  - A timer counts clocks while en = 1 and hall_q is unchanged.
  - It clears on every hall_q change and whenever en = 0.
  - When it reaches STALL_CYCLES, stall is set to 1 and all outputs are forced off.
  - stall is sticky until en = 0 or rst.
- Undefined: no timer logic is built and stall is tied to 0.

Test Plan:
- Reset: assert rst mid-drive -> A = B = C = 00, fault = 0 immediately, without waiting for a clock edge.
- First drive: en = 1, dir = 0, outputs off, H = 101 held -> {A,B,C} = 10,01,00 exactly 7 clocks later (defaults).
- Commutation: from 101 steady, H -> 100 -> outputs all 00 for exactly 8 clocks, then 10,00,01. Never 11 on any phase.
- Full cycle and reverse:
  - dir = 0, H stepped 101,100,110,010,011,001 (each held 50 clocks) -> the forward table in order.
  - dir = 1, H = 101 -> 01,10,00.
- Glitch and fault:
  - H = 101 steady; a 3-clock pulse to 111 -> no output change.
  - H = 111 held -> fault = 1 and outputs 00 one clock after acceptance.
  - en = 0 -> outputs 00 on the next clock.
- Stall (BLDC_STALL_DETECT_EN, STALL_CYCLES = 100): hold H constant with en = 1 -> stall = 1 and outputs 00. Toggling en to 0 clears stall.
